reg_dump_sequencer: RTL

- Synthesizable end-of-run observer that sits directly downstream of the single-cycle CPU's register file.
- Counts clock cycles after reset release and asserts a halt to the CPU after END_COUNT cycles.
- Then walks the register file read port over all NUM_REGS entries and emits each {index, value} pair on a valid/ready stream.
- The stream feeds a UART or trace sink in FPGA bring-up.

---
 rtl/reg_dump_pkg.sv | 27 ++
 rtl/reg_dump_sequencer_run_cycle_counter.sv | 28 ++
 rtl/reg_dump_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types, default widths and the checksum step for the register-dump sequencer.
package reg_dump_pkg;

  localparam int unsigned END_COUNT_DEF = 100;
  localparam int unsigned NUM_REGS_DEF  = 32;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned IDX_W_DEF     = 5;
  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned CKS_MAX_W     = 64;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Rotate acc left by one within w bits, then XOR in data; w must be 1..CKS_MAX_W.
  function automatic logic [CKS_MAX_W-1:0] cks_step(input logic [CKS_MAX_W-1:0] acc,
                                                    input logic [CKS_MAX_W-1:0] data,
                                                    input int unsigned          w);
    logic [CKS_MAX_W-1:0] mask;
    mask = (CKS_MAX_W'(1) << w) - CKS_MAX_W'(1);
    return (((acc << 1) | ((acc & mask) >> (w - 1))) & mask) ^ (data & mask);
  endfunction

endpackage

// File: rtl/reg_dump_sequencer_run_cycle_counter.sv
// Saturating run-cycle counter with enable; tc_c_o pulses on the edge that reaches END_COUNT.
module run_cycle_counter #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned END_COUNT = 100
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tc_c_o = en_i && (cnt_q == CNT_W'(END_COUNT - 1));
    if (en_i && (cnt_q != CNT_W'(END_COUNT))) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_dump_sequencer.sv
// End-of-run observer: halts the CPU after END_COUNT cycles, then streams every register
// as {index, value} beats. Define REG_DUMP_CHECKSUM_EN to enable the rotate-XOR checksum.
module reg_dump_sequencer
  import reg_dump_pkg::*;
#(
  parameter int unsigned END_COUNT = END_COUNT_DEF,
  parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned IDX_W     = IDX_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [IDX_W-1:0]  rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              cpu_halt_o,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [DATA_W-1:0] checksum_o
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                halt_q, halt_d;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    didx_q, didx_d;
  logic [DATA_W-1:0]   ddata_q, ddata_d;
  logic                done_q, done_d;
  logic                tc_c;
  logic                hs_c;
  logic                last_c;

  run_cycle_counter #(
    .CNT_W     (CNT_W),
    .END_COUNT (END_COUNT)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q == ST_RUN),
    .cnt_o  (cycle_cnt_o),
    .tc_c_o (tc_c)
  );

  assign hs_c   = (state_q == ST_SEND) && valid_q && dump_ready_i;
  assign last_c = (idx_q == IDX_W'(NUM_REGS - 1));

  // State register plus all datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      idx_q   <= '0;
      halt_q  <= 1'b0;
      valid_q <= 1'b0;
      didx_q  <= '0;
      ddata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      halt_q  <= halt_d;
      valid_q <= valid_d;
      didx_q  <= didx_d;
      ddata_q <= ddata_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (tc_c) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (hs_c) state_d = last_c ? ST_DONE : ST_LOAD;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    halt_d  = halt_q;
    valid_d = valid_q;
    didx_d  = didx_q;
    ddata_d = ddata_q;
    done_d  = done_q;
    case (state_q)
      ST_RUN:  if (tc_c) halt_d = 1'b1;
      ST_LOAD: begin
        valid_d = 1'b1;
        didx_d  = idx_q;
        ddata_d = rf_data_i;
      end
      ST_SEND: if (hs_c) begin
        valid_d = 1'b0;
        if (last_c) done_d = 1'b1;
        else        idx_d  = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (hs_c) cks_d = DATA_W'(cks_step(CKS_MAX_W'(cks_q), CKS_MAX_W'(ddata_q), DATA_W));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cks_q <= '0;
    else        cks_q <= cks_d;
  end

  assign checksum_o = cks_q;
`else
  assign checksum_o = '0;
`endif

  assign rf_addr_o    = idx_q;
  assign cpu_halt_o   = halt_q;
  assign dump_valid_o = valid_q;
  assign dump_idx_o   = didx_q;
  assign dump_data_o  = ddata_q;
  assign done_o       = done_q;

endmodule
